bus_arbiter: RTL and testbench
==============================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter BURST_MAX, default 4: maximum back-to-back transfers one requester may take before forced re-arbitration (legal range 1..15).
REQ-002 clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 mN_req (N=0,1)  input  1  requester N asks for one bus transfer; held until mN_done.
REQ-005 mN_we  input  1  1 = write, 0 = read; stable while mN_req=1.
REQ-006 mN_wob  input  1  word(1)/byte(0) select; stable while mN_req=1.
REQ-007 mN_addr  input  32  transfer address; stable while mN_req=1.
REQ-008 mN_wdata  input  32  write data; stable while mN_req=1.
REQ-009 mN_gnt  output  1  high during the XFER cycle owned by requester N.
REQ-010 mN_done  output  1  one-cycle completion pulse to requester N.
REQ-011 mN_rdata  output  32  read data, valid while mN_done=1; holds its value otherwise.
REQ-012 bus_wen / bus_ren  output  1 each  write/read enables to the memory/peripheral bus.
REQ-013 bus_wob, bus_addr[31:0], bus_wdata[31:0]  output  command to the bus.
REQ-014 bus_rdata  input  32  bus read data, combinationally valid within the XFER cycle.

Function
REQ-015 FSM states: IDLE, XFER, RESP.
REQ-016 IDLE: no request -> stay; any mN_req=1 -> choose winner, latch its command into internal registers, go to XFER.
REQ-017 XFER (exactly one cycle): bus_* driven from latched command; bus_wen=we, bus_ren=~we; winner's mN_gnt=1; at cycle end, capture bus_rdata into winner's mN_rdata on reads; go to RESP.
REQ-018 RESP (exactly one cycle): winner's mN_done=1; bus_wen=bus_ren=0; evaluate next transfer as in REQ-016 (-> XFER), or -> IDLE if no request.
REQ-019 Latency: req first seen high at edge k -> XFER during cycle k..k+1 -> done high the following cycle; two-cycle throughput per transfer.
REQ-020 Requester wanting another transfer keeps mN_req=1 through its done cycle with the new command presented in that cycle; otherwise deasserts req in the done cycle.
REQ-021 Burst counter: increments each time the same owner wins consecutively; when it reaches BURST_MAX and the other requester is pending, the other requester wins; counter clears on owner change or IDLE.
REQ-022 Outside XFER, bus_wen=bus_ren=0 and bus_addr/bus_wdata/bus_wob are 0.
REQ-023 At most one mN_gnt and one mN_done high in any cycle; never both bus_wen and bus_ren.
REQ-024 Requester dropping req without done: ignored if before winning; a latched transfer always completes.
REQ-025 Simultaneous requests: winner selected per REQ-028/REQ-029 and REQ-021.

Reset
REQ-026 reset low, any cycle: state IDLE; all outputs 0; mN_rdata 0; latched command 0; burst counter 0; priority pointer to requester 0.
REQ-027 Reset asserted mid-XFER aborts the transfer immediately; no done pulse is issued for it after release.

Configuration
REQ-028 Macro ARB_ROUND_ROBIN_EN defined: on simultaneous requests the requester not served last wins; pointer flips after each completed transfer.
REQ-029 Macro ARB_ROUND_ROBIN_EN undefined: requester 0 has fixed priority; requester 1 wins only when m0_req=0 or through the BURST_MAX limit of REQ-021.

Verification
REQ-030 Single read: m0 req, we=0, addr=0x00000004, bus_rdata=0x12345678 -> bus_ren one cycle, m0_done next cycle with m0_rdata=0x12345678.
REQ-031 Single write: m1 req, we=1, addr=0x40000010, wdata=0x00000F3F -> bus_wen one cycle with that addr/data, m1_done next cycle, m0 outputs idle.
REQ-032 Contention, round-robin: both req held for 4 transfers -> owners 0,1,0,1; no cycle with two gnt.
REQ-033 Fixed priority, BURST_MAX=4: both req held -> m0 wins 4 transfers, m1 wins 5th, m0 resumes.
REQ-034 Reset low during XFER -> all outputs 0 next edge; after release, no done pulse; fresh req served normally.
REQ-035 Back-to-back: m0 holds req with new addr in done cycle -> next XFER immediately follows RESP, no IDLE cycle.

Source files
------------

// File: rtl/bus_arbiter.sv
// Two-requester single-transfer bus arbiter: IDLE -> XFER -> RESP, with a per-owner burst limit.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise requester 0 has fixed priority.
module bus_arbiter #(
    parameter int unsigned BURST_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic        m0_wob,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_gnt,
    output logic        m0_done,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic        m1_wob,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_gnt,
    output logic        m1_done,
    output logic [31:0] m1_rdata,
    output logic        bus_wen,
    output logic        bus_ren,
    output logic        bus_wob,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata
);
    localparam logic [3:0] BURST_LIM = 4'(BURST_MAX);

    typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;

    state_t      state, state_nxt;
    logic        owner, owner_nxt;
    logic [3:0]  burst_cnt, burst_cnt_nxt;
    logic        load;
    logic        win;
    logic        base_pick;
    logic        cmd_we, cmd_wob;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        xfer;

`ifdef ARB_ROUND_ROBIN_EN
    // In RESP the current owner is the one served last, so the other side has priority.
    logic prio;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)             prio <= 1'b0;
        else if (state == RESP) prio <= ~owner;
    end
    assign base_pick = (state == RESP) ? ~owner : prio;
`else
    assign base_pick = 1'b0;
`endif

    always_comb begin
        win = 1'b0;
        if (!(m0_req && m1_req))
            win = m1_req;
        else if (state == RESP && owner == base_pick && burst_cnt == BURST_LIM)
            win = ~base_pick;
        else
            win = base_pick;
    end

    always_comb begin
        state_nxt     = state;
        owner_nxt     = owner;
        burst_cnt_nxt = burst_cnt;
        load          = 1'b0;
        case (state)
            IDLE: begin
                if (m0_req || m1_req) begin
                    state_nxt     = XFER;
                    owner_nxt     = win;
                    burst_cnt_nxt = 4'd1;
                    load          = 1'b1;
                end
            end
            XFER: state_nxt = RESP;
            RESP: begin
                if (m0_req || m1_req) begin
                    state_nxt = XFER;
                    owner_nxt = win;
                    load      = 1'b1;
                    if (win != owner)
                        burst_cnt_nxt = 4'd1;
                    else if (burst_cnt != BURST_LIM)
                        burst_cnt_nxt = burst_cnt + 4'd1;
                end else begin
                    state_nxt     = IDLE;
                    burst_cnt_nxt = 4'd0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            owner     <= 1'b0;
            burst_cnt <= 4'd0;
            cmd_we    <= 1'b0;
            cmd_wob   <= 1'b0;
            cmd_addr  <= 32'd0;
            cmd_wdata <= 32'd0;
            m0_rdata  <= 32'd0;
            m1_rdata  <= 32'd0;
        end else begin
            state     <= state_nxt;
            owner     <= owner_nxt;
            burst_cnt <= burst_cnt_nxt;
            if (load) begin
                cmd_we    <= win ? m1_we    : m0_we;
                cmd_wob   <= win ? m1_wob   : m0_wob;
                cmd_addr  <= win ? m1_addr  : m0_addr;
                cmd_wdata <= win ? m1_wdata : m0_wdata;
            end
            if (state == XFER && !cmd_we) begin
                if (owner) m1_rdata <= bus_rdata;
                else       m0_rdata <= bus_rdata;
            end
        end
    end

    assign xfer      = (state == XFER);
    assign m0_gnt    = xfer & ~owner;
    assign m1_gnt    = xfer & owner;
    assign m0_done   = (state == RESP) & ~owner;
    assign m1_done   = (state == RESP) & owner;
    assign bus_wen   = xfer & cmd_we;
    assign bus_ren   = xfer & ~cmd_we;
    assign bus_wob   = xfer & cmd_wob;
    assign bus_addr  = xfer ? cmd_addr  : 32'd0;
    assign bus_wdata = xfer ? cmd_wdata : 32'd0;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: transaction-level reference model checked every cycle, directed cases, random traffic.
module tb_bus_arbiter;
    localparam int BURST_MAX = 4;

    typedef struct packed {
        logic        we;
        logic        wob;
        logic [31:0] addr;
        logic [31:0] wdata;
    } cmd_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        m0_req = 1'b0, m0_we = 1'b0, m0_wob = 1'b0;
    logic [31:0] m0_addr = 32'd0, m0_wdata = 32'd0;
    logic        m1_req = 1'b0, m1_we = 1'b0, m1_wob = 1'b0;
    logic [31:0] m1_addr = 32'd0, m1_wdata = 32'd0;
    logic        m0_gnt, m0_done, m1_gnt, m1_done;
    logic [31:0] m0_rdata, m1_rdata;
    logic        bus_wen, bus_ren, bus_wob;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;

    logic        rd_ovr_en = 1'b0;
    logic [31:0] rd_ovr = 32'd0;

    int n_cmp = 0;
    int n_bad = 0;

    bus_arbiter #(.BURST_MAX(BURST_MAX)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_wob(m0_wob), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_done(m0_done), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_wob(m1_wob), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_done(m1_done), .m1_rdata(m1_rdata),
        .bus_wen(bus_wen), .bus_ren(bus_ren), .bus_wob(bus_wob),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    // Slave returns an address-derived word unless a directed test forces a value.
    assign bus_rdata = rd_ovr_en ? rd_ovr : {bus_addr[15:0], ~bus_addr[31:16]};

    function automatic logic [31:0] rd_val(input logic [31:0] a);
        return rd_ovr_en ? rd_ovr : {a[15:0], ~a[31:16]};
    endfunction

    function automatic cmd_t cmd_of(input int n);
        return (n == 0) ? cmd_t'({m0_we, m0_wob, m0_addr, m0_wdata})
                        : cmd_t'({m1_we, m1_wob, m1_addr, m1_wdata});
    endfunction

    function automatic cmd_t mk(input logic we, input logic wob, input logic [31:0] a, input logic [31:0] d);
        cmd_t c;
        c.we = we; c.wob = wob; c.addr = a; c.wdata = d;
        return c;
    endfunction

    function automatic cmd_t rand_cmd();
        return mk(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom);
    endfunction

    task automatic put(input int n, input logic rq, input cmd_t c);
        if (n == 0) begin
            m0_req = rq; m0_we = c.we; m0_wob = c.wob; m0_addr = c.addr; m0_wdata = c.wdata;
        end else begin
            m1_req = rq; m1_we = c.we; m1_wob = c.wob; m1_addr = c.addr; m1_wdata = c.wdata;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: one transfer in flight, either in its bus phase or its done phase.
    bit          mdl_busy = 1'b0;
    bit          mdl_resp = 1'b0;
    int          mdl_own = 0;
    cmd_t        mdl_cmd = '0;
    int          chain_own = -1;
    int          chain_len = 0;
    int          rr_pref = 0;
    logic [31:0] mdl_rd [2] = '{32'd0, 32'd0};

    initial begin
        int w;
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                mdl_busy = 1'b0; mdl_resp = 1'b0; mdl_own = 0; mdl_cmd = '0;
                chain_own = -1; chain_len = 0; rr_pref = 0;
                mdl_rd[0] = 32'd0; mdl_rd[1] = 32'd0;
            end else if (mdl_busy && !mdl_resp) begin
                mdl_resp = 1'b1;
                if (!mdl_cmd.we) mdl_rd[mdl_own] = rd_val(mdl_cmd.addr);
            end else begin
                if (mdl_busy) rr_pref = 1 - mdl_own;
                if (m0_req || m1_req) begin
                    if (m0_req && m1_req) begin
`ifdef ARB_ROUND_ROBIN_EN
                        w = rr_pref;
`else
                        w = 0;
`endif
                        if (w == chain_own && chain_len >= BURST_MAX) w = 1 - w;
                    end else begin
                        w = m1_req ? 1 : 0;
                    end
                    if (w == chain_own) chain_len++;
                    else begin chain_own = w; chain_len = 1; end
                    mdl_busy = 1'b1; mdl_resp = 1'b0; mdl_own = w; mdl_cmd = cmd_of(w);
                end else begin
                    mdl_busy = 1'b0; mdl_resp = 1'b0; chain_own = -1; chain_len = 0;
                end
            end
        end
    end

    initial begin
        logic [134:0] act_v, exp_v;
        logic xf, g0, g1, d0, d1;
        forever begin
            @(negedge clk);
            xf = mdl_busy && !mdl_resp;
            g0 = xf && mdl_own == 0;
            g1 = xf && mdl_own == 1;
            d0 = mdl_busy && mdl_resp && mdl_own == 0;
            d1 = mdl_busy && mdl_resp && mdl_own == 1;
            exp_v = {g0, d0, mdl_rd[0], g1, d1, mdl_rd[1],
                     xf && mdl_cmd.we, xf && !mdl_cmd.we, xf && mdl_cmd.wob,
                     xf ? mdl_cmd.addr : 32'd0, xf ? mdl_cmd.wdata : 32'd0};
            act_v = {m0_gnt, m0_done, m0_rdata, m1_gnt, m1_done, m1_rdata,
                     bus_wen, bus_ren, bus_wob, bus_addr, bus_wdata};
            n_cmp++;
            if (act_v !== exp_v) begin
                n_bad++;
                $display("FAIL cycle_model t=%0t got=%h want=%h", $time, act_v, exp_v);
            end
        end
    end

    initial begin
        int exp_own [6];
        int waited;
        int p;
`ifdef ARB_ROUND_ROBIN_EN
        exp_own = '{0, 1, 0, 1, 0, 1};
`else
        exp_own = '{0, 0, 0, 0, 1, 0};
`endif
        #2 reset = 1'b0;
        @(negedge clk);
        chk("reset_outputs", 32'({bus_wen, bus_ren, m0_gnt, m1_gnt, m0_done, m1_done}), 32'd0);
        chk("reset_rdata", m0_rdata | m1_rdata, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // single read
        rd_ovr_en = 1'b1; rd_ovr = 32'h12345678;
        put(0, 1'b1, mk(1'b0, 1'b1, 32'h00000004, 32'd0));
        @(negedge clk);
        chk("rd_xfer_ren", 32'(bus_ren), 32'd1);
        chk("rd_xfer_addr", bus_addr, 32'h00000004);
        chk("rd_xfer_gnt", 32'(m0_gnt), 32'd1);
        @(negedge clk);
        chk("rd_done", 32'(m0_done), 32'd1);
        chk("rd_data", m0_rdata, 32'h12345678);
        put(0, 1'b0, '0);
        @(negedge clk);
        chk("rd_idle_done", 32'(m0_done), 32'd0);
        rd_ovr_en = 1'b0;

        // single write
        put(1, 1'b1, mk(1'b1, 1'b1, 32'h40000010, 32'h00000F3F));
        @(negedge clk);
        chk("wr_xfer_en", 32'({bus_wen, bus_ren}), 32'd2);
        chk("wr_xfer_addr", bus_addr, 32'h40000010);
        chk("wr_xfer_data", bus_wdata, 32'h00000F3F);
        chk("wr_xfer_gnt", 32'({m0_gnt, m1_gnt}), 32'd1);
        @(negedge clk);
        chk("wr_done", 32'({m0_done, m1_done}), 32'd1);
        put(1, 1'b0, '0);
        @(negedge clk);

        // contention with both requests held
        put(0, 1'b1, rand_cmd());
        put(1, 1'b1, rand_cmd());
        for (int i = 0; i < 6; i++) begin
            waited = 0;
            @(negedge clk);
            while (!(m0_done || m1_done) && waited < 8) begin
                @(negedge clk);
                waited++;
            end
            if (!(m0_done || m1_done)) begin
                n_cmp++; n_bad++;
                $display("FAIL contend_timeout got=no_done want=done t=%0t", $time);
                break;
            end
            chk("contend_owner", m1_done ? 32'd1 : 32'd0, 32'(exp_own[i]));
            if (i < 5) put(m1_done ? 1 : 0, 1'b1, rand_cmd());
            else begin put(0, 1'b0, '0); put(1, 1'b0, '0); end
        end
        repeat (2) @(negedge clk);

        // reset during the bus phase aborts the transfer
        put(0, 1'b1, mk(1'b0, 1'b0, 32'h00000100, 32'd0));
        @(negedge clk);
        chk("abort_xfer_gnt", 32'(m0_gnt), 32'd1);
        #1 reset = 1'b0;
        put(0, 1'b0, '0);
        @(negedge clk);
        chk("abort_outputs", 32'({bus_wen, bus_ren, m0_gnt, m1_gnt, m0_done, m1_done}), 32'd0);
        chk("abort_bus_addr", bus_addr, 32'd0);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_no_done", 32'({m0_done, m1_done}), 32'd0);
        end
        put(1, 1'b1, mk(1'b0, 1'b0, 32'h00000200, 32'd0));
        @(negedge clk);
        chk("post_abort_gnt", 32'(m1_gnt), 32'd1);
        @(negedge clk);
        chk("post_abort_done", 32'(m1_done), 32'd1);
        chk("post_abort_rdata", m1_rdata, 32'h0200FFFF);
        put(1, 1'b0, '0);
        @(negedge clk);

        // back-to-back from one requester
        put(0, 1'b1, mk(1'b1, 1'b0, 32'h00000010, 32'h0000AAAA));
        @(negedge clk);
        @(negedge clk);
        chk("b2b_done1", 32'(m0_done), 32'd1);
        put(0, 1'b1, mk(1'b1, 1'b0, 32'h00000020, 32'h00005555));
        @(negedge clk);
        chk("b2b_gnt2", 32'(m0_gnt), 32'd1);
        chk("b2b_addr2", bus_addr, 32'h00000020);
        chk("b2b_wen2", 32'(bus_wen), 32'd1);
        @(negedge clk);
        chk("b2b_done2", 32'(m0_done), 32'd1);
        put(0, 1'b0, '0);
        @(negedge clk);
        chk("b2b_idle", 32'({m0_gnt, m0_done}), 32'd0);

        // random traffic from two independent masters
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            if (cyc == 1500) begin
                #1 reset = 1'b0;
                @(negedge clk);
                reset = 1'b1;
            end
            p = ((cyc / 500) % 2 == 1) ? 90 : 30;
            for (int n = 0; n < 2; n++) begin
                logic rq, dn, gn;
                rq = (n == 0) ? m0_req  : m1_req;
                dn = (n == 0) ? m0_done : m1_done;
                gn = (n == 0) ? m0_gnt  : m1_gnt;
                if (!rq) begin
                    if ($urandom_range(0, 99) < p) put(n, 1'b1, rand_cmd());
                end else if (dn) begin
                    if ($urandom_range(0, 1) == 1) put(n, 1'b1, rand_cmd());
                    else put(n, 1'b0, '0);
                end else if (!gn && $urandom_range(0, 99) < 5) begin
                    put(n, 1'b0, '0);
                end
            end
        end
        put(0, 1'b0, '0);
        put(1, 1'b0, '0);
        repeat (4) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
